// File: rtl/jtag_dtm_dr.sv
// RISC-V debug transport data registers (DTMCS and DMI) behind a JTAG TAP.
// Turns completed DMI scans into a valid/ready request/response exchange with the Debug Module.
module jtag_dtm_dr #(
  parameter int unsigned           IR_WIDTH = 5,
  parameter logic [IR_WIDTH-1:0]   IR_DTMCS = 5'h10,
  parameter logic [IR_WIDTH-1:0]   IR_DMI   = 5'h11,
  parameter int unsigned           ABITS    = 7,
  parameter logic [2:0]            IDLE     = 3'd1
) (
  input  logic                TCLK,
  input  logic                TRSTn,
  input  logic [IR_WIDTH-1:0] ir,
  input  logic                dr_capture,
  input  logic                dr_shift,
  input  logic                dr_update,
  input  logic                TDI,
  output logic                dr_tdo,
  output logic                dmi_req_valid,
  input  logic                dmi_req_ready,
  output logic [ABITS-1:0]    dmi_req_addr,
  output logic [31:0]         dmi_req_data,
  output logic [1:0]          dmi_req_op,
  input  logic                dmi_resp_valid,
  output logic                dmi_resp_ready,
  input  logic [31:0]         dmi_resp_data,
  input  logic [1:0]          dmi_resp_err,
  output logic                dmi_hardreset
);

  localparam int unsigned DW = ABITS + 34;

  logic [DW-1:0]    sr, sr_n;
  logic             busy, busy_n;
  logic             accepted, acc_n;
  logic [1:0]       sticky, sticky_n;
  logic [ABITS-1:0] addr_n;
  logic [31:0]      data_n;
  logic [1:0]       op_n;
  logic [31:0]      rdata_lat, rdata_n;
  logic             valid_n;
  logic             hr_n;

  logic             sel_dtmcs, sel_dmi;
  logic [1:0]       st_cap;
  logic [31:0]      dtmcs_cap;

  assign sel_dtmcs      = (ir == IR_DTMCS);
  assign sel_dmi        = (ir == IR_DMI);
  assign dr_tdo         = (sel_dtmcs || sel_dmi) ? sr[0] : 1'b0;
  assign dmi_resp_ready = 1'b1;

  // busy is the registered value, so a response in the capture cycle still reports busy
  assign st_cap    = busy ? 2'd3 : sticky;
  assign dtmcs_cap = {14'b0, 3'b0, IDLE, sticky, 6'(ABITS), 4'd1};

  // Effects are layered in order: handshake, capture side effect, response, then scan update,
  // so an update in a response cycle sees busy already cleared.
  always_comb begin
    sr_n     = sr;
    busy_n   = busy;
    acc_n    = accepted;
    sticky_n = sticky;
    addr_n   = dmi_req_addr;
    data_n   = dmi_req_data;
    op_n     = dmi_req_op;
    rdata_n  = rdata_lat;
    valid_n  = dmi_req_valid;
    hr_n     = 1'b0;

    if (dmi_req_valid && dmi_req_ready) begin
      valid_n = 1'b0;
      acc_n   = 1'b1;
    end

    if (sel_dmi && dr_capture && busy && (sticky == 2'd0))
      sticky_n = 2'd3;

    if (dmi_resp_valid && busy && accepted) begin
      rdata_n = dmi_resp_data;
      busy_n  = 1'b0;
      acc_n   = 1'b0;
      if ((dmi_resp_err != 2'd0) && (sticky_n != 2'd3))
        sticky_n = 2'd2;
    end

    if (sel_dtmcs) begin
      if (dr_capture) begin
        sr_n       = '0;
        sr_n[31:0] = dtmcs_cap;
      end else if (dr_shift) begin
        sr_n[31:0] = {TDI, sr[31:1]};
      end else if (dr_update) begin
        if (sr[17]) begin
          sticky_n = 2'd0;
          busy_n   = 1'b0;
          acc_n    = 1'b0;
          valid_n  = 1'b0;
          hr_n     = 1'b1;
        end else if (sr[16]) begin
          sticky_n = 2'd0;
        end
      end
    end else if (sel_dmi) begin
      if (dr_capture) begin
        sr_n = {dmi_req_addr, rdata_lat, st_cap};
      end else if (dr_shift) begin
        sr_n = {TDI, sr[DW-1:1]};
      end else if (dr_update && (sticky_n == 2'd0)) begin
        if (busy_n) begin
          sticky_n = 2'd3;
        end else if ((sr[1:0] == 2'd1) || (sr[1:0] == 2'd2)) begin
          addr_n  = sr[DW-1:34];
          data_n  = sr[33:2];
          op_n    = sr[1:0];
          valid_n = 1'b1;
          busy_n  = 1'b1;
          acc_n   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge TCLK or negedge TRSTn) begin
    if (!TRSTn) begin
      sr            <= '0;
      busy          <= 1'b0;
      accepted      <= 1'b0;
      sticky        <= '0;
      dmi_req_addr  <= '0;
      dmi_req_data  <= '0;
      dmi_req_op    <= '0;
      rdata_lat     <= '0;
      dmi_req_valid <= 1'b0;
      dmi_hardreset <= 1'b0;
    end else begin
      sr            <= sr_n;
      busy          <= busy_n;
      accepted      <= acc_n;
      sticky        <= sticky_n;
      dmi_req_addr  <= addr_n;
      dmi_req_data  <= data_n;
      dmi_req_op    <= op_n;
      rdata_lat     <= rdata_n;
      dmi_req_valid <= valid_n;
      dmi_hardreset <= hr_n;
    end
  end

endmodule

// File: tb/tb_jtag_dtm_dr.sv
// Directed bench for jtag_dtm_dr: DTMCS/DMI scans, request handshake, sticky status, resets.
module tb_jtag_dtm_dr;

  logic        TCLK;
  logic        TRSTn;
  logic [4:0]  ir;
  logic        dr_capture, dr_shift, dr_update, TDI;
  logic        dr_tdo;
  logic        dmi_req_valid, dmi_req_ready;
  logic [6:0]  dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;
  logic        dmi_resp_valid, dmi_resp_ready;
  logic [31:0] dmi_resp_data;
  logic [1:0]  dmi_resp_err;
  logic        dmi_hardreset;

  int total = 0;
  int bad   = 0;
  logic [40:0] dout;

  jtag_dtm_dr #(
    .IR_WIDTH (5),
    .IR_DTMCS (5'h10),
    .IR_DMI   (5'h11),
    .ABITS    (7),
    .IDLE     (3'd1)
  ) dut (
    .TCLK           (TCLK),
    .TRSTn          (TRSTn),
    .ir             (ir),
    .dr_capture     (dr_capture),
    .dr_shift       (dr_shift),
    .dr_update      (dr_update),
    .TDI            (TDI),
    .dr_tdo         (dr_tdo),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_ready  (dmi_req_ready),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_data   (dmi_req_data),
    .dmi_req_op     (dmi_req_op),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_ready (dmi_resp_ready),
    .dmi_resp_data  (dmi_resp_data),
    .dmi_resp_err   (dmi_resp_err),
    .dmi_hardreset  (dmi_hardreset)
  );

  initial TCLK = 1'b0;
  always #5 TCLK = ~TCLK;

  task automatic tick();
    @(posedge TCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Capture, n shift cycles (TDO sampled before each shifting edge), then update.
  task automatic dr_scan(input logic [4:0] irv, input logic [40:0] din,
                         input int unsigned n, output logic [40:0] dq);
    dq = '0;
    ir = irv;
    dr_capture = 1'b1;
    tick();
    dr_capture = 1'b0;
    dr_shift   = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      TDI   = din[i];
      dq[i] = dr_tdo;
      tick();
    end
    dr_shift  = 1'b0;
    TDI       = 1'b0;
    dr_update = 1'b1;
    tick();
    dr_update = 1'b0;
  endtask

  task automatic accept_and_respond(input logic [31:0] rd, input logic [1:0] err);
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    tick();
    dmi_resp_valid = 1'b1;
    dmi_resp_data  = rd;
    dmi_resp_err   = err;
    tick();
    dmi_resp_valid = 1'b0;
    dmi_resp_data  = '0;
    dmi_resp_err   = '0;
  endtask

  initial begin
    TRSTn = 1'b0;
    ir = 5'h00; dr_capture = 1'b0; dr_shift = 1'b0; dr_update = 1'b0; TDI = 1'b0;
    dmi_req_ready = 1'b0; dmi_resp_valid = 1'b0; dmi_resp_data = '0; dmi_resp_err = '0;
    repeat (2) tick();
    chk("rst_valid", 64'(dmi_req_valid), 64'd0);
    chk("rst_hardreset", 64'(dmi_hardreset), 64'd0);
    chk("rst_tdo", 64'(dr_tdo), 64'd0);
    chk("rst_req", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
    chk("resp_ready", 64'(dmi_resp_ready), 64'd1);
    TRSTn = 1'b1;
    tick();

    // Unselected IR: scan is ignored, TDO stays low
    dr_scan(5'h01, '1, 41, dout);
    chk("bypass_ir_tdo", 64'(dout), 64'd0);

    // DTMCS read
    dr_scan(5'h10, '0, 32, dout);
    chk("dtmcs_read", 64'(dout), 64'h1071);

    // DMI write with ready held low for three cycles
    dr_scan(5'h11, {7'h10, 32'hDEADBEEF, 2'd2}, 41, dout);
    chk("dmi_first_capture", 64'(dout), 64'd0);
    chk("wr_valid", 64'(dmi_req_valid), 64'd1);
    chk("wr_req", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'({7'h10, 32'hDEADBEEF, 2'd2}));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_valid_hold", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}),
          64'({1'b1, 7'h10, 32'hDEADBEEF, 2'd2}));
    end
    dmi_req_ready = 1'b1;
    #1;
    chk("wr_valid_with_ready", 64'(dmi_req_valid), 64'd1);
    tick();
    dmi_req_ready = 1'b0;
    chk("wr_valid_drop", 64'(dmi_req_valid), 64'd0);
    tick();
    dmi_resp_valid = 1'b1;
    tick();
    dmi_resp_valid = 1'b0;

    // DMI read
    dr_scan(5'h11, {7'h04, 32'h0, 2'd1}, 41, dout);
    chk("rd_capture_prev", 64'(dout), 64'({7'h10, 32'h0, 2'd0}));
    chk("rd_req", 64'({dmi_req_valid, dmi_req_addr, dmi_req_op}), 64'({1'b1, 7'h04, 2'd1}));
    accept_and_respond(32'h12345678, 2'd0);
    dr_scan(5'h11, '0, 41, dout);
    chk("rd_result", 64'(dout), 64'({7'h04, 32'h12345678, 2'd0}));
    chk("nop_no_req", 64'(dmi_req_valid), 64'd0);

    // Busy: second update before response
    dr_scan(5'h11, {7'h05, 32'h0, 2'd1}, 41, dout);
    dr_scan(5'h11, {7'h06, 32'h77, 2'd2}, 41, dout);
    chk("busy_capture", 64'(dout), 64'({7'h05, 32'h12345678, 2'd3}));
    chk("busy_no_new_req", 64'({dmi_req_valid, dmi_req_addr, dmi_req_op}), 64'({1'b1, 7'h05, 2'd1}));
    accept_and_respond(32'hCAFEF00D, 2'd0);
    dr_scan(5'h11, '0, 41, dout);
    chk("busy_sticky", 64'(dout), 64'({7'h05, 32'hCAFEF00D, 2'd3}));
    dr_scan(5'h10, 41'h10000, 32, dout);
    chk("dtmcs_sticky3", 64'(dout), 64'h1C71);
    dr_scan(5'h11, '0, 41, dout);
    chk("busy_cleared", 64'(dout), 64'({7'h05, 32'hCAFEF00D, 2'd0}));

    // Error response
    dr_scan(5'h11, {7'h08, 32'h0, 2'd1}, 41, dout);
    accept_and_respond(32'h0BADBAD0, 2'd2);
    dr_scan(5'h11, {7'h09, 32'hA5A5A5A5, 2'd2}, 41, dout);
    chk("err_capture", 64'(dout), 64'({7'h08, 32'h0BADBAD0, 2'd2}));
    chk("err_blocks_req", 64'(dmi_req_valid), 64'd0);
    dr_scan(5'h10, 41'h10000, 32, dout);
    chk("dtmcs_sticky2", 64'(dout), 64'h1871);
    dr_scan(5'h11, {7'h09, 32'hA5A5A5A5, 2'd2}, 41, dout);
    chk("err_cleared_capture", 64'(dout), 64'({7'h08, 32'h0BADBAD0, 2'd0}));
    chk("err_cleared_req", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}),
        64'({1'b1, 7'h09, 32'hA5A5A5A5, 2'd2}));
    accept_and_respond(32'h11112222, 2'd0);

    // Hardreset with request outstanding
    dr_scan(5'h11, {7'h0A, 32'h0, 2'd1}, 41, dout);
    chk("hr_req", 64'(dmi_req_valid), 64'd1);
    dr_scan(5'h10, 41'h20000, 32, dout);
    chk("hr_valid_drop", 64'(dmi_req_valid), 64'd0);
    chk("hr_pulse", 64'(dmi_hardreset), 64'd1);
    tick();
    chk("hr_pulse_end", 64'(dmi_hardreset), 64'd0);
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'h55555555; dmi_resp_err = 2'd2;
    tick();
    dmi_resp_valid = 1'b0; dmi_resp_data = '0; dmi_resp_err = '0;
    dr_scan(5'h11, '0, 41, dout);
    chk("hr_late_resp", 64'(dout), 64'({7'h0A, 32'h11112222, 2'd0}));

    // TRSTn mid-request
    dr_scan(5'h11, {7'h0C, 32'hFEEDFACE, 2'd2}, 41, dout);
    chk("trst_req", 64'(dmi_req_valid), 64'd1);
    #2 TRSTn = 1'b0;
    #1;
    chk("trst_outputs", 64'({dmi_req_valid, dmi_hardreset, dr_tdo, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
    #3 TRSTn = 1'b1;
    tick();
    dmi_resp_valid = 1'b1; dmi_resp_data = 32'h99999999;
    tick();
    dmi_resp_valid = 1'b0; dmi_resp_data = '0;
    dr_scan(5'h11, '0, 41, dout);
    chk("trst_late_resp", 64'(dout), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
